// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad scanner: key codes, matrix size,
// debounce state encoding and the row/column to key-code map.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE  = 4'd15;
  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_SHARP = 4'd11;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } deb_state_t;

  // Rows 0-2 carry digits 1-9 in reading order; row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = KEY_NONE;
    if (col > 2'd2) begin
      code = KEY_NONE;
    end else begin
      case (row)
        2'd0, 2'd1, 2'd2: code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        2'd3: begin
          case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'd0;
            2'd2:    code = KEY_SHARP;
            default: code = KEY_NONE;
          endcase
        end
        default: code = KEY_NONE;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-rate debouncer: a new key code (or a release) must repeat for
// DEBOUNCE_CNT consecutive frame results before it becomes the output code.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_valid,
  input  logic [3:0] i_frame_result,
  output logic [3:0] o_key_code
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  deb_state_t    r_state;
  logic [3:0]    r_cand;
  logic [3:0]    r_code;
  logic [CW-1:0] r_count;

  // Debounce state machine, advanced once per completed scan frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cand  <= KEY_NONE;
      r_code  <= KEY_NONE;
      r_count <= '0;
    end else if (i_frame_valid) begin
      case (r_state)
        IDLE: begin
          if (i_frame_result != KEY_NONE) begin
            if (DEBOUNCE_CNT == 1) begin
              r_code  <= i_frame_result;
              r_state <= HELD;
            end else begin
              r_state <= CONFIRM;
              r_cand  <= i_frame_result;
              r_count <= CW'(1);
            end
          end
        end
        HELD: begin
          if (i_frame_result != r_code) begin
            if (DEBOUNCE_CNT == 1) begin
              r_code  <= i_frame_result;
              r_state <= (i_frame_result == KEY_NONE) ? IDLE : HELD;
            end else begin
              r_state <= CONFIRM;
              r_cand  <= i_frame_result;
              r_count <= CW'(1);
            end
          end
        end
        CONFIRM: begin
          if (i_frame_result == r_cand) begin
            if ((r_count + CW'(1)) == CW'(DEBOUNCE_CNT)) begin
              r_code  <= r_cand;
              r_state <= (r_cand == KEY_NONE) ? IDLE : HELD;
              r_count <= '0;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end else begin
            // A bounce back to the current output abandons the candidate.
            r_cand  <= i_frame_result;
            r_count <= CW'(1);
            if (i_frame_result == r_code) begin
              r_state <= (r_code == KEY_NONE) ? IDLE : HELD;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cand  <= KEY_NONE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign o_key_code = r_code;

endmodule

// File: rtl/keypad_scan.sv
// 4x3 matrix keypad scanner: drives one row low at a time, samples the
// synchronized columns, resolves one key per frame and debounces it.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_in,
  output logic [3:0] row_out,
  output logic [9:0] keypad,
  output logic       sharp,
  output logic       star,
  output logic [3:0] key_code
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [2:0]    r_col_meta;
  logic [2:0]    r_col_sync;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_row;
  logic [1:0]    r_hits;
  logic [3:0]    r_acc_code;

  logic          w_sample;
  logic          w_frame_valid;
  logic [1:0]    w_hits;
  logic [3:0]    w_acc_code;
  logic [3:0]    w_frame_result;
  logic [3:0]    w_db_code;

  // Two-flop synchronizer for the asynchronous column lines (idle high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_meta <= 3'b111;
      r_col_sync <= 3'b111;
    end else begin
      r_col_meta <= col_in;
      r_col_sync <= r_col_meta;
    end
  end

  assign w_sample      = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_frame_valid = w_sample && (r_row == 2'(NUM_ROWS - 1));

  // Fold the current row's closed columns into the frame accumulator.
  always_comb begin
    w_hits     = r_hits;
    w_acc_code = r_acc_code;
    for (int c = 0; c < NUM_COLS; c++) begin
      w_hits     = (!r_col_sync[c] && (w_hits != 2'd2)) ? (w_hits + 2'd1) : w_hits;
      w_acc_code = !r_col_sync[c] ? key_lookup(r_row, 2'(c)) : w_acc_code;
    end
    w_frame_result = (w_hits == 2'd1) ? w_acc_code : KEY_NONE;
  end

  // Row dwell counter, row rotation and per-frame accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell    <= '0;
      r_row      <= 2'd0;
      row_out    <= 4'b1110;
      r_hits     <= 2'd0;
      r_acc_code <= KEY_NONE;
    end else if (w_sample) begin
      r_dwell <= '0;
      r_row   <= r_row + 2'd1;
      row_out <= {row_out[2:0], row_out[3]};
      if (w_frame_valid) begin
        r_hits     <= 2'd0;
        r_acc_code <= KEY_NONE;
      end else begin
        r_hits     <= w_hits;
        r_acc_code <= w_acc_code;
      end
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  key_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_valid (w_frame_valid),
    .i_frame_result(w_frame_result),
    .o_key_code    (w_db_code)
  );

  // Registered one-hot decode of the debounced code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code <= KEY_NONE;
      keypad   <= 10'd0;
      sharp    <= 1'b0;
      star     <= 1'b0;
    end else begin
      key_code <= w_db_code;
      keypad   <= (w_db_code <= 4'd9) ? (10'd1 << w_db_code) : 10'd0;
      sharp    <= (w_db_code == KEY_SHARP);
      star     <= (w_db_code == KEY_STAR);
    end
  end

endmodule
